// File: rtl/seq_pkg.sv
// seq_pkg: shared types and field constants for the datapath sequencer.
package seq_pkg;

   // One state per control step of the fetch/execute sequence
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_T6   = 3'd7
   } state_t;

   localparam int OPCODE_W    = 5;   // opcode occupies the top bits of IR
   localparam int ALU_CTRL_W  = 4;   // low opcode bits drive the ALU directly
   localparam int ILLEGAL_BIT = 4;   // opcodes with this bit set are rejected

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: register index plus enable to a one-hot select vector.
module onehot_dec #(
   parameter int N = 16,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [W-1:0] idx,
   input  logic         en,
   output logic [N-1:0] onehot
);

   // Each output bit compares the index against its own position
   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == W'(gi));
   end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: single-instruction fetch/execute control FSM.
// Build option: define SEQ_MEM_WAIT_EN to make T2 stall until mem_ready;
// without it mem_ready is ignored and T2 always lasts one cycle.
module datapath_sequencer
   import seq_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mem_ready,
   input  logic [DATA_W-1:0]     ir,
   output logic                  pc_out,
   output logic                  pc_in,
   output logic                  mar_in,
   output logic                  inc_pc,
   output logic                  z_in,
   output logic                  zlo_out,
   output logic                  md_read,
   output logic                  mdr_in,
   output logic                  mdr_out,
   output logic                  ir_in,
   output logic                  ry_in,
   output logic [NUM_REGS-1:0]   reg_out_sel,
   output logic [NUM_REGS-1:0]   reg_in_sel,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal
);

   localparam int RW        = $clog2(NUM_REGS);
   localparam int FIELD_LSB = DATA_W - OPCODE_W - 3 * RW;

   state_t              state;
   state_t              state_next;
   logic [OPCODE_W-1:0] opcode;
   logic [RW-1:0]       ra;
   logic [RW-1:0]       rb;
   logic [RW-1:0]       rc;
   logic                illegal_op;
   logic                in_t4;      // registered "now in T4"
   logic                in_t5;      // registered "now in T5"
   logic                out_en;
   logic [RW-1:0]       out_idx;

   // IR fields are taken live: IR is only valid once T3 has loaded it
   assign opcode     = ir[DATA_W-1 -: OPCODE_W];
   assign ra         = ir[DATA_W-1-OPCODE_W -: RW];
   assign rb         = ir[DATA_W-1-OPCODE_W-RW -: RW];
   assign rc         = ir[DATA_W-1-OPCODE_W-2*RW -: RW];
   assign illegal_op = opcode[ILLEGAL_BIT];

   if (FIELD_LSB > 0) begin : g_ir_low
      logic unused_ir_low;
      assign unused_ir_low = ^ir[FIELD_LSB-1:0];
   end

   // State register; reset abandons any instruction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state sequencing; start only matters in IDLE and T6
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (start) state_next = S_T0;
         S_T0:   state_next = S_T1;
         S_T1:   state_next = S_T2;
`ifdef SEQ_MEM_WAIT_EN
         S_T2:   if (mem_ready) state_next = S_T3;
`else
         S_T2:   state_next = S_T3;
`endif
         S_T3:   state_next = S_T4;
         S_T4:   state_next = illegal_op ? S_IDLE : S_T5;
         S_T5:   state_next = S_T6;
         S_T6:   state_next = start ? S_T0 : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Strobes decoded from the state being entered so they are glitch-free flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_out  <= 1'b0;
         mar_in  <= 1'b0;
         inc_pc  <= 1'b0;
         z_in    <= 1'b0;
         zlo_out <= 1'b0;
         pc_in   <= 1'b0;
         md_read <= 1'b0;
         mdr_out <= 1'b0;
         ir_in   <= 1'b0;
         in_t4   <= 1'b0;
         in_t5   <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         pc_out  <= (state_next == S_T0);
         mar_in  <= (state_next == S_T0);
         inc_pc  <= (state_next == S_T0);
         z_in    <= (state_next == S_T0) || (state_next == S_T5);
         zlo_out <= (state_next == S_T1) || (state_next == S_T6);
         pc_in   <= (state_next == S_T1);
         md_read <= (state_next == S_T2);
         mdr_out <= (state_next == S_T3);
         ir_in   <= (state_next == S_T3);
         in_t4   <= (state_next == S_T4);
         in_t5   <= (state_next == S_T5);
         done    <= (state_next == S_T6);
         busy    <= (state_next != S_IDLE);
      end
   end

`ifdef SEQ_MEM_WAIT_EN
   // Capture read data only in the T2 cycle where memory actually returns it
   assign mdr_in = md_read & mem_ready;
`else
   assign mdr_in = md_read;
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
`endif

   // Operand/ALU controls combine the registered phase with the loaded IR
   assign illegal  = in_t4 & illegal_op;
   assign ry_in    = in_t4 & ~illegal_op;
   assign out_en   = ry_in | in_t5;
   assign out_idx  = in_t5 ? rc : rb;
   assign alu_ctrl = in_t5 ? opcode[ALU_CTRL_W-1:0] : '0;

   onehot_dec #(.N(NUM_REGS), .W(RW)) u_out_dec (
      .idx    (out_idx),
      .en     (out_en),
      .onehot (reg_out_sel)
   );

   // Writeback happens only in T6, which is also the done cycle
   onehot_dec #(.N(NUM_REGS), .W(RW)) u_in_dec (
      .idx    (ra),
      .en     (done),
      .onehot (reg_in_sel)
   );

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: random and directed checks of two sequencer
// instances (16 and 32 registers) against a per-cycle timeline model.
`timescale 1ns/1ps
module tb_datapath_sequencer;

`ifdef SEQ_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   typedef struct packed {
      logic busy, done, illegal;
      logic pc_out, pc_in, mar_in, inc_pc, z_in, zlo_out;
      logic md_read, mdr_in, mdr_out, ir_in, ry_in;
      logic [3:0]  alu;
      logic [31:0] out_sel;
      logic [31:0] in_sel;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset, start, mem_ready;
   logic [31:0] ir_a, ir_b;

   logic a_pc_out, a_pc_in, a_mar_in, a_inc_pc, a_z_in, a_zlo_out;
   logic a_md_read, a_mdr_in, a_mdr_out, a_ir_in, a_ry_in, a_busy, a_done, a_illegal;
   logic [15:0] a_out_sel, a_in_sel;
   logic [3:0]  a_alu;
   logic b_pc_out, b_pc_in, b_mar_in, b_inc_pc, b_z_in, b_zlo_out;
   logic b_md_read, b_mdr_in, b_mdr_out, b_ir_in, b_ry_in, b_busy, b_done, b_illegal;
   logic [31:0] b_out_sel, b_in_sel;
   logic [3:0]  b_alu;
   obs_t obs_a, obs_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   datapath_sequencer #(.DATA_W(32), .NUM_REGS(16)) dut_a (
      .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready), .ir(ir_a),
      .pc_out(a_pc_out), .pc_in(a_pc_in), .mar_in(a_mar_in), .inc_pc(a_inc_pc),
      .z_in(a_z_in), .zlo_out(a_zlo_out), .md_read(a_md_read), .mdr_in(a_mdr_in),
      .mdr_out(a_mdr_out), .ir_in(a_ir_in), .ry_in(a_ry_in),
      .reg_out_sel(a_out_sel), .reg_in_sel(a_in_sel), .alu_ctrl(a_alu),
      .busy(a_busy), .done(a_done), .illegal(a_illegal)
   );

   datapath_sequencer #(.DATA_W(32), .NUM_REGS(32)) dut_b (
      .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready), .ir(ir_b),
      .pc_out(b_pc_out), .pc_in(b_pc_in), .mar_in(b_mar_in), .inc_pc(b_inc_pc),
      .z_in(b_z_in), .zlo_out(b_zlo_out), .md_read(b_md_read), .mdr_in(b_mdr_in),
      .mdr_out(b_mdr_out), .ir_in(b_ir_in), .ry_in(b_ry_in),
      .reg_out_sel(b_out_sel), .reg_in_sel(b_in_sel), .alu_ctrl(b_alu),
      .busy(b_busy), .done(b_done), .illegal(b_illegal)
   );

   assign obs_a = {a_busy, a_done, a_illegal, a_pc_out, a_pc_in, a_mar_in, a_inc_pc,
                   a_z_in, a_zlo_out, a_md_read, a_mdr_in, a_mdr_out, a_ir_in, a_ry_in,
                   a_alu, 16'h0, a_out_sel, 16'h0, a_in_sel};
   assign obs_b = {b_busy, b_done, b_illegal, b_pc_out, b_pc_in, b_mar_in, b_inc_pc,
                   b_z_in, b_zlo_out, b_md_read, b_mdr_in, b_mdr_out, b_ir_in, b_ry_in,
                   b_alu, b_out_sel, b_in_sel};

   task automatic check_val(input string tag, input obs_t got, input obs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected outputs for a given step of the instruction timeline:
   // 0 idle, 1 T0, 2 T1, 3 T2, 4 T3, 5 T4, 6 T5, 7 T6.
   function automatic obs_t model(input int ph, input logic [31:0] irv, input int rw,
                                  input logic mr);
      obs_t e;
      int op, ra, rb, rc, mask;
      e    = '0;
      mask = (1 << rw) - 1;
      op   = int'(irv[31:27]);
      ra   = int'(irv >> (27 - rw)) & mask;
      rb   = int'(irv >> (27 - 2 * rw)) & mask;
      rc   = int'(irv >> (27 - 3 * rw)) & mask;
      if (ph == 0) return e;
      e.busy = 1'b1;
      case (ph)
         1: begin e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1; end
         2: begin e.zlo_out = 1'b1; e.pc_in = 1'b1; end
         3: begin e.md_read = 1'b1; e.mdr_in = WAIT_EN ? mr : 1'b1; end
         4: begin e.mdr_out = 1'b1; e.ir_in = 1'b1; end
         5: begin
            if (op >= 16) e.illegal = 1'b1;
            else begin e.out_sel = 32'd1 << rb; e.ry_in = 1'b1; end
         end
         6: begin e.out_sel = 32'd1 << rc; e.alu = 4'(op & 15); e.z_in = 1'b1; end
         7: begin e.zlo_out = 1'b1; e.in_sel = 32'd1 << ra; e.done = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   // One clock cycle: drive inputs, sample mid-cycle, advance past the next edge
   task automatic step(input int ph, input logic st, input logic mr, input string tag);
      start     = st;
      mem_ready = mr;
      #1;
      check_val({tag, "/r16"}, obs_a, model(ph, ir_a, 4, mr));
      check_val({tag, "/r32"}, obs_b, model(ph, ir_b, 5, mr));
      @(posedge clk);
      #1;
   endtask

   // Cycles T0..T6 of one instruction; start noise is driven where it must be ignored
   task automatic run_instr(input logic [31:0] ia, input logic [31:0] ib,
                            input int waits, input logic chain);
      int n2;
      ir_a = ia;
      ir_b = ib;
      n2   = WAIT_EN ? waits + 1 : 1;
      $display("txn ir16=%h ir32=%h waits=%0d chain=%0d", ia, ib, waits, chain);
      step(1, rbit(), rbit(), "T0");
      step(2, rbit(), rbit(), "T1");
      for (int i = 0; i < n2; i++)
         step(3, rbit(), WAIT_EN ? (i == n2 - 1) : rbit(), "T2");
      step(4, rbit(), rbit(), "T3");
      step(5, rbit(), rbit(), "T4");
      if (!ia[31]) begin
         step(6, rbit(), rbit(), "T5");
         step(7, chain, rbit(), "T6");
      end
   endtask

   initial begin
      logic [4:0] op;
      logic       chain, chained;
      reset = 1'b1; start = 1'b0; mem_ready = 1'b0; ir_a = '0; ir_b = '0;
      #3;
      check_val("reset/r16", obs_a, '0);
      check_val("reset/r32", obs_b, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Nominal instruction; 32-register copy uses ra=31 rb=0 rc=17
      step(0, 1'b1, 1'b1, "issue");
      run_instr(32'h4A920000, 32'h4FC11000, 0, 1'b0);
      step(0, 1'b0, 1'b1, "idle");

      // Three wait cycles in T2 (only stretch the fetch when waiting is built in)
      step(0, 1'b1, 1'b0, "issue");
      run_instr(32'h4A920000, 32'h4FC11000, 3, 1'b0);
      step(0, 1'b0, 1'b1, "idle");

      // Illegal opcode 17: aborts after T4, idle on the very next cycle
      step(0, 1'b1, 1'b1, "issue");
      run_instr(32'h8A920000, 32'h8FC11000, 0, 1'b0);
      step(0, 1'b0, 1'b1, "post_illegal");

      // Back-to-back: T6 with start goes straight to T0
      step(0, 1'b1, 1'b1, "issue");
      run_instr(32'h4A920000, 32'h4FC11000, 0, 1'b1);
      run_instr(32'h4A920000, 32'h4FC11000, 0, 1'b0);
      step(0, 1'b0, 1'b1, "idle");

      // Reset asserted in the middle of T4
      ir_a = 32'h4A920000; ir_b = 32'h4FC11000;
      $display("txn reset-in-T4 ir16=%h ir32=%h", ir_a, ir_b);
      step(0, 1'b1, 1'b1, "issue");
      step(1, 1'b0, 1'b1, "T0");
      step(2, 1'b0, 1'b1, "T1");
      step(3, 1'b0, 1'b1, "T2");
      step(4, 1'b0, 1'b1, "T3");
      #1;
      check_val("T4_pre_rst/r16", obs_a, model(5, ir_a, 4, 1'b1));
      check_val("T4_pre_rst/r32", obs_b, model(5, ir_b, 5, 1'b1));
      reset = 1'b1;
      #1;
      check_val("rst_async/r16", obs_a, '0);
      check_val("rst_async/r32", obs_b, '0);
      start = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_hold/r16", obs_a, '0);
      check_val("rst_hold/r32", obs_b, '0);
      reset = 1'b0;
      step(0, 1'b1, 1'b1, "issue_after_rst");
      run_instr(32'h4A920000, 32'h4FC11000, 1, 1'b0);

      // Randomized instruction stream
      chained = 1'b0;
      for (int t = 0; t < 24; t++) begin
         op = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) op[4] = 1'b0;
         chain = (t < 23) && rbit() && !op[4];
         if (!chained) begin
            if (rbit()) step(0, 1'b0, rbit(), "idle");
            step(0, 1'b1, rbit(), "issue");
         end
         run_instr({op, 27'($urandom)}, {op, 27'($urandom)}, $urandom_range(0, 3), chain);
         chained = chain;
      end
      step(0, 1'b0, 1'b1, "final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
